// File: rtl/uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module      : uart_alu_interface
// Description : Collects A/B/opcode bytes from the UART receiver, presents them
//               to an external ALU and hands the result to the UART transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_alu_interface #(
    parameter int NB_DATA        = 8,
    parameter int NB_OP          = 6,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               rx_done_tick,
    input  logic [7:0]         rx_dout,
    input  logic [NB_DATA-1:0] alu_result,
    output logic [NB_DATA-1:0] alu_a,
    output logic [NB_DATA-1:0] alu_b,
    output logic [NB_OP-1:0]   alu_op,
    output logic               tx_start,
    output logic [7:0]         tx_din,
    input  logic               tx_done_tick,
    output logic               busy,
    output logic               timeout_tick
);

    typedef enum logic [2:0] {
        ST_WAIT_A    = 3'd0,
        ST_WAIT_B    = 3'd1,
        ST_WAIT_OP   = 3'd2,
        ST_CALC      = 3'd3,
        ST_SEND      = 3'd4,
        ST_WAIT_DONE = 3'd5
    } state_t;

    state_t             r_state;
    state_t             w_next_state;
    logic               w_timeout;
    logic [NB_DATA-1:0] r_alu_a;
    logic [NB_DATA-1:0] r_alu_b;
    logic [NB_OP-1:0]   r_alu_op;
    logic [7:0]         r_tx_din;
    logic               r_timeout_tick;

    generate
        if (TIMEOUT_CYCLES > 0) begin : g_timeout_en
            localparam logic [31:0] c_limit = 32'(TIMEOUT_CYCLES - 1);
            logic [31:0] r_count;
            logic        w_counting;

            assign w_counting = (r_state == ST_WAIT_B) || (r_state == ST_WAIT_OP);
            // An arriving byte always wins over an expiring counter.
            assign w_timeout  = w_counting && !rx_done_tick && (r_count == c_limit);

            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_count <= 32'd0;
                end else if (!w_counting || rx_done_tick || w_timeout) begin
                    r_count <= 32'd0;
                end else begin
                    r_count <= r_count + 32'd1;
                end
            end
        end else begin : g_timeout_dis
            assign w_timeout = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_WAIT_A;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_WAIT_A: begin
                if (rx_done_tick) w_next_state = ST_WAIT_B;
            end
            ST_WAIT_B: begin
                if (rx_done_tick)   w_next_state = ST_WAIT_OP;
                else if (w_timeout) w_next_state = ST_WAIT_A;
            end
            ST_WAIT_OP: begin
                if (rx_done_tick)   w_next_state = ST_CALC;
                else if (w_timeout) w_next_state = ST_WAIT_A;
            end
            ST_CALC:      w_next_state = ST_SEND;
            ST_SEND:      w_next_state = ST_WAIT_DONE;
            ST_WAIT_DONE: begin
                if (tx_done_tick) w_next_state = ST_WAIT_A;
            end
            default:      w_next_state = ST_WAIT_A;
        endcase
    end

    // Operands persist across aborted frames; only a new accepted byte replaces them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alu_a        <= '0;
            r_alu_b        <= '0;
            r_alu_op       <= '0;
            r_tx_din       <= 8'd0;
            r_timeout_tick <= 1'b0;
        end else begin
            r_timeout_tick <= w_timeout;
            if (rx_done_tick && r_state == ST_WAIT_A)  r_alu_a  <= rx_dout;
            if (rx_done_tick && r_state == ST_WAIT_B)  r_alu_b  <= rx_dout;
            if (rx_done_tick && r_state == ST_WAIT_OP) r_alu_op <= rx_dout[NB_OP-1:0];
            if (r_state == ST_CALC)                    r_tx_din <= alu_result;
        end
    end

    assign alu_a        = r_alu_a;
    assign alu_b        = r_alu_b;
    assign alu_op       = r_alu_op;
    assign tx_din       = r_tx_din;
    assign timeout_tick = r_timeout_tick;
    assign tx_start     = (r_state == ST_SEND);
    assign busy         = (r_state == ST_CALC) || (r_state == ST_SEND) ||
                          (r_state == ST_WAIT_DONE);

endmodule
`default_nettype wire

// File: tb/tb_uart_alu_interface.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_alu_interface
// Description : Self-checking bench with a behavioural ALU and tx_din scoreboard.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_alu_interface;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       rx_done_tick = 1'b0;
    logic [7:0] rx_dout = 8'd0;
    logic       tx_done_tick = 1'b0;
    logic [7:0] alu_result, alu_a, alu_b, tx_din;
    logic [5:0] alu_op;
    logic       tx_start, busy, timeout_tick;

    logic       rx0_done_tick = 1'b0;
    logic [7:0] rx0_dout = 8'd0;
    logic       tx0_done_tick = 1'b0;
    logic [7:0] alu0_result, alu0_a, alu0_b, tx0_din;
    logic [5:0] alu0_op;
    logic       tx0_start, busy0, timeout0_tick;

    int errors = 0;
    int checks = 0;
    int n_tx_start = 0;
    int n_tmo = 0;
    int n_tmo0 = 0;
    logic [7:0] q_exp[$];

    always #5 clk = ~clk;

    function automatic logic [7:0] alu_model(input logic [7:0] a, input logic [7:0] b,
                                             input logic [5:0] op);
        case (op)
            6'h20:   return a + b;
            6'h22:   return a - b;
            default: return a ^ b;
        endcase
    endfunction

    assign alu_result  = alu_model(alu_a, alu_b, alu_op);
    assign alu0_result = alu_model(alu0_a, alu0_b, alu0_op);

    always @(negedge clk) begin
        if (tx_start)      n_tx_start++;
        if (timeout_tick)  n_tmo++;
        if (timeout0_tick) n_tmo0++;
    end

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(100)) dut (
        .clk(clk), .reset(reset), .rx_done_tick(rx_done_tick), .rx_dout(rx_dout),
        .alu_result(alu_result), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op),
        .tx_start(tx_start), .tx_din(tx_din), .tx_done_tick(tx_done_tick),
        .busy(busy), .timeout_tick(timeout_tick)
    );

    uart_alu_interface #(.NB_DATA(8), .NB_OP(6), .TIMEOUT_CYCLES(0)) dut0 (
        .clk(clk), .reset(reset), .rx_done_tick(rx0_done_tick), .rx_dout(rx0_dout),
        .alu_result(alu0_result), .alu_a(alu0_a), .alu_b(alu0_b), .alu_op(alu0_op),
        .tx_start(tx0_start), .tx_din(tx0_din), .tx_done_tick(tx0_done_tick),
        .busy(busy0), .timeout_tick(timeout0_tick)
    );

    task automatic send_byte(input logic [7:0] b);
        @(posedge clk); #1;
        rx_dout = b;
        rx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] a, input logic [7:0] b, input logic [7:0] op);
        send_byte(a);
        send_byte(b);
        send_byte(op);
        q_exp.push_back(alu_model(a, b, op[5:0]));
        checks++;
        if ({alu_a, alu_b, alu_op} !== {a, b, op[5:0]}) begin
            errors++;
            $display("FAIL operands: got %h/%h/%h expected %h/%h/%h",
                     alu_a, alu_b, alu_op, a, b, op[5:0]);
        end
    endtask

    // Called right after the opcode byte: tx_start must follow one cycle later.
    task automatic expect_tx(input string name);
        int k = 0;
        logic [7:0] exp;
        while (!tx_start && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if (!tx_start) begin
            errors++;
            $display("FAIL %s tx_start: got none within %0d cycles expected pulse", name, k);
        end else begin
            checks++;
            if (k != 1) begin
                errors++;
                $display("FAIL %s latency: got %0d expected 1", name, k);
            end
            exp = (q_exp.size() > 0) ? q_exp.pop_front() : 8'hxx;
            checks++;
            if (tx_din !== exp) begin
                errors++;
                $display("FAIL %s tx_din: got %h expected %h", name, tx_din, exp);
            end
            @(posedge clk); #1;
            checks++;
            if ({tx_start, busy, tx_din} !== {1'b0, 1'b1, exp}) begin
                errors++;
                $display("FAIL %s after_send: got start=%b busy=%b din=%h expected 0 1 %h",
                         name, tx_start, busy, tx_din, exp);
            end
        end
    endtask

    task automatic finish_tx(input string name);
        @(posedge clk); #1;
        tx_done_tick = 1'b1;
        @(posedge clk); #1;
        tx_done_tick = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL %s busy_after_done: got %b expected 0", name, busy);
        end
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        @(negedge clk) reset = 1'b0;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick} !== '0) begin
            errors++;
            $display("FAIL reset_state: got %h/%h/%h/%h %b%b%b expected all zero",
                     alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick);
        end
    endtask

    task automatic test_add();
        int s0 = n_tx_start;
        send_frame(8'h05, 8'h03, 8'h20);
        checks++;
        if ({busy, tx_start} !== 2'b10) begin
            errors++;
            $display("FAIL add_calc: got busy=%b start=%b expected 1 0", busy, tx_start);
        end
        expect_tx("add");
        finish_tx("add");
        checks++;
        if (n_tx_start - s0 != 1) begin
            errors++;
            $display("FAIL add_pulses: got %0d expected 1", n_tx_start - s0);
        end
    endtask

    task automatic test_sub_and_discard();
        send_frame(8'h10, 8'h01, 8'hE2);
        expect_tx("sub");
        send_byte(8'hAA);
        checks++;
        if ({busy, alu_a, alu_b} !== {1'b1, 8'h10, 8'h01}) begin
            errors++;
            $display("FAIL discard_aa: got busy=%b a=%h b=%h expected 1 10 01", busy, alu_a, alu_b);
        end
        @(posedge clk); #1;
        rx_dout = 8'hBB; rx_done_tick = 1'b1; tx_done_tick = 1'b1;
        @(posedge clk); #1;
        rx_done_tick = 1'b0; tx_done_tick = 1'b0;
        checks++;
        if ({busy, alu_a} !== {1'b0, 8'h10}) begin
            errors++;
            $display("FAIL discard_bb: got busy=%b a=%h expected 0 10", busy, alu_a);
        end
        send_frame(8'h01, 8'h02, 8'h20);
        expect_tx("after_discard");
        finish_tx("after_discard");
    endtask

    task automatic test_timeout();
        for (int nb = 1; nb <= 2; nb++) begin
            int k = 0;
            int s0 = n_tx_start;
            int t0 = n_tmo;
            send_byte(8'h40 + 8'(nb));
            if (nb == 2) send_byte(8'h66);
            while (!timeout_tick && k < 200) begin
                @(posedge clk); #1;
                k++;
            end
            checks++;
            if (k != 100) begin
                errors++;
                $display("FAIL timeout_delay%0d: got %0d expected 100", nb, k);
            end
            @(posedge clk); #1;
            checks++;
            if ({timeout_tick, busy, n_tmo - t0, n_tx_start - s0, alu_a} !==
                {1'b0, 1'b0, 32'd1, 32'd0, 8'h40 + 8'(nb)}) begin
                errors++;
                $display("FAIL timeout_after%0d: got tick=%b busy=%b pulses=%0d starts=%0d a=%h expected 0 0 1 0 %h",
                         nb, timeout_tick, busy, n_tmo - t0, n_tx_start - s0, alu_a, 8'h40 + 8'(nb));
            end
        end
        send_frame(8'h07, 8'h02, 8'h20);
        expect_tx("post_timeout");
        finish_tx("post_timeout");
    endtask

    task automatic test_timeout_boundary();
        int t0 = n_tmo;
        send_byte(8'h11);
        repeat (98) @(posedge clk);
        send_byte(8'h22);
        checks++;
        if ({alu_b, n_tmo - t0} !== {8'h22, 32'd0}) begin
            errors++;
            $display("FAIL boundary_byte: got b=%h pulses=%0d expected 22 0", alu_b, n_tmo - t0);
        end
        send_byte(8'h20);
        q_exp.push_back(8'h33);
        expect_tx("boundary");
        finish_tx("boundary");
        checks++;
        if (n_tmo != t0) begin
            errors++;
            $display("FAIL boundary_tmo: got %0d pulses expected 0", n_tmo - t0);
        end
    endtask

    task automatic test_no_timeout();
        int k = 0;
        @(posedge clk); #1;
        rx0_dout = 8'h04; rx0_done_tick = 1'b1;
        @(posedge clk); #1;
        rx0_done_tick = 1'b0;
        repeat (20000) @(posedge clk);
        #1;
        checks++;
        if ({n_tmo0, busy0} !== {32'd0, 1'b0}) begin
            errors++;
            $display("FAIL no_timeout: got pulses=%0d busy=%b expected 0 0", n_tmo0, busy0);
        end
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            rx0_dout = (i == 0) ? 8'h05 : 8'h20; rx0_done_tick = 1'b1;
            @(posedge clk); #1;
            rx0_done_tick = 1'b0;
        end
        while (!tx0_start && k < 20) begin
            @(posedge clk); #1;
            k++;
        end
        checks++;
        if ({tx0_start, tx0_din, k} !== {1'b1, 8'h09, 32'd1}) begin
            errors++;
            $display("FAIL no_timeout_frame: got start=%b din=%h lat=%0d expected 1 09 1",
                     tx0_start, tx0_din, k);
        end
        @(posedge clk); #1;
        tx0_done_tick = 1'b1;
        @(posedge clk); #1;
        tx0_done_tick = 1'b0;
    endtask

    task automatic test_async_reset();
        send_frame(8'h03, 8'h04, 8'h20);
        expect_tx("pre_reset");
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick} !== '0) begin
            errors++;
            $display("FAIL reset_wait_done: got %h/%h/%h/%h %b%b%b expected all zero",
                     alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick);
        end
        @(negedge clk) reset = 1'b0;
        send_byte(8'h09);
        send_byte(8'h0A);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick} !== '0) begin
            errors++;
            $display("FAIL reset_wait_op: got %h/%h/%h/%h %b%b%b expected all zero",
                     alu_a, alu_b, alu_op, tx_din, tx_start, busy, timeout_tick);
        end
        @(negedge clk) reset = 1'b0;
        send_frame(8'h0C, 8'h04, 8'h22);
        expect_tx("post_reset");
        finish_tx("post_reset");
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub_and_discard();
        test_timeout();
        test_timeout_boundary();
        test_no_timeout();
        test_async_reset();
        checks++;
        if (q_exp.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_left: got %0d entries expected 0", q_exp.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #3000000;
        $display("FAIL watchdog: got no completion expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
